// File: rtl/cpu6_trap_ctrl_pkg.sv
// Shared constants and state encoding for the cpu6 machine-mode trap controller.
// Cause values match the mcause encoding the CSR block will adopt.
package cpu6_trap_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] CAUSE_MTI     = 32'h8000_0007;
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 32'h0000_0002;
    localparam logic [XLEN-1:0] CAUSE_ECALL_M = 32'h0000_000b;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_MRET    = 2'd3
    } trap_state_e;

endpackage

// File: rtl/cpu6_trap_ctrl_dffrs.sv
// Flop with asynchronous active-high reset that forces every bit to 1.
// Used for state that must come out of reset asserted, such as the global interrupt enable.
module cpu6_trap_ctrl_dffrs #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '1;
        else       q <= d;
    end

endmodule

// File: rtl/cpu6_trap_ctrl.sv
// Machine-mode trap controller: picks trap/mret at EX boundaries, drives the mepc write,
// flush and fetch redirect one cycle later, and owns the MIE bit.
module cpu6_trap_ctrl
    import cpu6_trap_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_ecall,
    input  logic            ex_illegal,
    input  logic            ex_mret,
    input  logic            tmr_irq_r,
    input  logic            csr_mtie_r,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic [XLEN-1:0] excp_mepc,
    output logic            excp_mepc_ena,
    output logic [XLEN-1:0] trap_cause,
    output logic            trap_cause_ena,
    output logic            flush,
    output logic            redirect_ena,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mie_r,
    output logic [1:0]      trap_state
);

    trap_state_e     state;
    trap_state_e     state_nxt;
    logic            bnd;
    logic            irq;
    logic            take_trap;
    logic            take_mret;
    logic [XLEN-1:0] cause_nxt;
    logic            mie_nxt;

    assign bnd        = ex_valid & ~ex_stall;
    // Interrupts are naturally masked in HANDLER because mie_r is 0 there.
    assign irq        = tmr_irq_r & csr_mtie_r & mie_r;
    assign trap_state = state;

    always_comb begin
        state_nxt = state;
        take_trap = 1'b0;
        take_mret = 1'b0;
        cause_nxt = trap_cause;
        case (state)
            ST_RUN, ST_HANDLER: begin
                if (bnd) begin
                    if (irq) begin
                        take_trap = 1'b1;
                        cause_nxt = CAUSE_MTI;
                    end else if (ex_illegal || (ex_mret && state == ST_RUN)) begin
                        take_trap = 1'b1;
                        cause_nxt = CAUSE_ILLEGAL;
                    end else if (ex_ecall) begin
                        take_trap = 1'b1;
                        cause_nxt = CAUSE_ECALL_M;
                    end else if (ex_mret) begin
                        take_mret = 1'b1;
                    end
                end
                if (take_trap)      state_nxt = ST_ENTER;
                else if (take_mret) state_nxt = ST_MRET;
            end
            // EX is being flushed in these one-cycle states, so its inputs are ignored.
            ST_ENTER: state_nxt = ST_HANDLER;
            ST_MRET:  state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        mie_nxt = mie_r;
        if (state == ST_ENTER)     mie_nxt = 1'b0;
        else if (state == ST_MRET) mie_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_RUN;
            excp_mepc      <= '0;
            excp_mepc_ena  <= 1'b0;
            trap_cause     <= '0;
            trap_cause_ena <= 1'b0;
            flush          <= 1'b0;
            redirect_ena   <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_nxt;
            excp_mepc_ena  <= take_trap;
            trap_cause_ena <= take_trap;
            flush          <= take_trap | take_mret;
            redirect_ena   <= take_trap | take_mret;
            if (take_trap) begin
                excp_mepc   <= ex_pc;
                trap_cause  <= cause_nxt;
                redirect_pc <= csr_mtvec;
            end else if (take_mret) begin
                redirect_pc <= csr_mepc;
            end
        end
    end

    cpu6_trap_ctrl_dffrs #(.W(1)) u_mie (
        .clk   (clk),
        .reset (reset),
        .d     (mie_nxt),
        .q     (mie_r)
    );

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// Directed bench for cpu6_trap_ctrl: stimulus pushes expected redirect events into a queue,
// a negedge monitor pops and compares whenever the DUT strobes a redirect.
module tb_cpu6_trap_ctrl;

    localparam int EW = 97; // {is_trap, redirect_pc, mepc, cause}

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_stall, ex_ecall, ex_illegal, ex_mret;
    logic [31:0] ex_pc;
    logic        tmr_irq_r, csr_mtie_r;
    logic [31:0] csr_mtvec, csr_mepc;
    logic [31:0] excp_mepc, trap_cause, redirect_pc;
    logic        excp_mepc_ena, trap_cause_ena, flush, redirect_ena, mie_r;
    logic [1:0]  trap_state;

    logic [EW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    cpu6_trap_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_pc          (ex_pc),
        .ex_ecall       (ex_ecall),
        .ex_illegal     (ex_illegal),
        .ex_mret        (ex_mret),
        .tmr_irq_r      (tmr_irq_r),
        .csr_mtie_r     (csr_mtie_r),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .excp_mepc      (excp_mepc),
        .excp_mepc_ena  (excp_mepc_ena),
        .trap_cause     (trap_cause),
        .trap_cause_ena (trap_cause_ena),
        .flush          (flush),
        .redirect_ena   (redirect_ena),
        .redirect_pc    (redirect_pc),
        .mie_r          (mie_r),
        .trap_state     (trap_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks: called at posedge+1, return at posedge+1
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic boundary(input logic [31:0] pc, input logic ec, input logic il, input logic mr);
        ex_pc = pc; ex_ecall = ec; ex_illegal = il; ex_mret = mr;
        ex_valid = 1'b1; ex_stall = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_ecall = 1'b0; ex_illegal = 1'b0; ex_mret = 1'b0;
    endtask

    function automatic logic [EW-1:0] exp_trap(input logic [31:0] mepc, input logic [31:0] cause);
        return {1'b1, 32'h0000_8000, mepc, cause};
    endfunction

    function automatic logic [EW-1:0] exp_mret(input logic [31:0] target);
        return {1'b0, target, 64'h0};
    endfunction

    // Scoreboard monitor
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && (redirect_ena || flush || excp_mepc_ena || trap_cause_ena)) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got redirect_pc %h mepc_ena %0b expected no event",
                             redirect_pc, excp_mepc_ena);
                end else begin
                    e = exp_q.pop_front();
                    check("redirect_ena", {31'd0, redirect_ena}, 32'd1);
                    check("flush", {31'd0, flush}, 32'd1);
                    check("redirect_pc", redirect_pc, e[95:64]);
                    check("mepc_ena", {31'd0, excp_mepc_ena}, {31'd0, e[96]});
                    check("cause_ena", {31'd0, trap_cause_ena}, {31'd0, e[96]});
                    if (e[96]) begin
                        check("excp_mepc", excp_mepc, e[63:32]);
                        check("trap_cause", trap_cause, e[31:0]);
                    end
                end
            end
        end
    end

    task automatic enter_check(input string name);
        step(1);
        check({name, "_mie"}, {31'd0, mie_r}, 32'd0);
        check({name, "_state"}, {30'd0, trap_state}, 32'd2);
    endtask

    task automatic do_mret(input logic [31:0] target);
        csr_mepc = target;
        exp_q.push_back(exp_mret(target));
        boundary(32'h0000_8040, 1'b0, 1'b0, 1'b1);
        step(1);
        check("mret_mie", {31'd0, mie_r}, 32'd1);
        check("mret_state", {30'd0, trap_state}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        ex_valid = 0; ex_stall = 0; ex_ecall = 0; ex_illegal = 0; ex_mret = 0;
        ex_pc = 0; tmr_irq_r = 0; csr_mtie_r = 0;
        csr_mtvec = 32'h0000_8000; csr_mepc = 0;
        step(2);
        check("rst_mie", {31'd0, mie_r}, 32'd1);
        check("rst_state", {30'd0, trap_state}, 32'd0);
        check("rst_mepc", excp_mepc, 32'd0);
        check("rst_cause", trap_cause, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_strobes", {28'd0, excp_mepc_ena, trap_cause_ena, flush, redirect_ena}, 32'd0);
        reset = 1'b0;
        step(1);

        // Timer interrupt at 0x100
        csr_mtie_r = 1'b1; tmr_irq_r = 1'b1;
        exp_q.push_back(exp_trap(32'h100, 32'h8000_0007));
        boundary(32'h100, 1'b0, 1'b0, 1'b0);
        enter_check("irq");

        // mret with irq still pending, then irq retaken at next boundary
        do_mret(32'h100);
        exp_q.push_back(exp_trap(32'h104, 32'h8000_0007));
        boundary(32'h104, 1'b0, 1'b0, 1'b0);
        enter_check("irq_retake");
        tmr_irq_r = 1'b0;
        do_mret(32'h104);

        // ecall held under stall for 3 cycles
        ex_pc = 32'h200; ex_ecall = 1'b1; ex_valid = 1'b1; ex_stall = 1'b1;
        step(3);
        exp_q.push_back(exp_trap(32'h200, 32'd11));
        boundary(32'h200, 1'b1, 1'b0, 1'b0);
        enter_check("ecall");
        do_mret(32'h204);

        // Priority: irq over illegal over ecall
        tmr_irq_r = 1'b1;
        exp_q.push_back(exp_trap(32'h240, 32'h8000_0007));
        boundary(32'h240, 1'b1, 1'b1, 1'b0);
        enter_check("prio_irq");
        do_mret(32'h240);
        csr_mtie_r = 1'b0;
        exp_q.push_back(exp_trap(32'h280, 32'd2));
        boundary(32'h280, 1'b1, 1'b1, 1'b0);
        enter_check("prio_illegal");
        tmr_irq_r = 1'b0;
        do_mret(32'h280);

        // mret outside a handler, then ecall from inside the handler
        exp_q.push_back(exp_trap(32'h300, 32'd2));
        boundary(32'h300, 1'b0, 1'b0, 1'b1);
        enter_check("mret_in_run");
        exp_q.push_back(exp_trap(32'h8010, 32'd11));
        boundary(32'h8010, 1'b1, 1'b0, 1'b0);
        enter_check("nested_ecall");
        do_mret(32'h304);

        // Reset during TRAP_ENTER aborts the trap
        boundary(32'h400, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("abort_strobes", {28'd0, excp_mepc_ena, trap_cause_ena, flush, redirect_ena}, 32'd0);
        check("abort_redirect_pc", redirect_pc, 32'd0);
        check("abort_mie", {31'd0, mie_r}, 32'd1);
        check("abort_state", {30'd0, trap_state}, 32'd0);
        step(2);
        reset = 1'b0;
        step(4);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
